// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with one instruction per line and single-word refill.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_CNT_EN.
module icache_dm #(
    parameter int ADDR  = 32,
    parameter int INST  = 32,
    parameter int LINES = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_e_,
    input  logic [ADDR-1:0] fetch_pc,
    output logic            ic_e_,
    output logic [ADDR-1:0] ic_pc,
    output logic [INST-1:0] ic_inst,
    output logic            mem_req_,
    output logic [ADDR-1:0] mem_addr,
    input  logic            mem_ack_,
    input  logic [INST-1:0] mem_inst,
    input  logic            inv_
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]     perf_hit,
    output logic [31:0]     perf_miss
`endif
);

    localparam int IDX  = $clog2(LINES);
    localparam int TAGW = ADDR - IDX - 2;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_MISS = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;

    logic [LINES-1:0] valid_r;
    logic [TAGW-1:0]  tag_r  [LINES];
    logic [INST-1:0]  data_r [LINES];
    logic [ADDR-1:0]  pc_r;

    logic [IDX-1:0]   req_idx_s;
    logic [TAGW-1:0]  req_tag_s;
    logic [IDX-1:0]   fill_idx_s;
    logic             hit_s;
    logic             accept_s;
    logic             fill_s;

    logic             ic_e_nxt_s;
    logic [ADDR-1:0]  ic_pc_nxt_s;
    logic [INST-1:0]  ic_inst_nxt_s;
    logic             mem_req_nxt_s;
    logic [ADDR-1:0]  mem_addr_nxt_s;

    assign req_idx_s  = fetch_pc[IDX+1:2];
    assign req_tag_s  = fetch_pc[ADDR-1:IDX+2];
    assign fill_idx_s = pc_r[IDX+1:2];
    assign hit_s      = valid_r[req_idx_s] && (tag_r[req_idx_s] == req_tag_s);
    assign accept_s   = (state_r == ST_RUN) && !fetch_e_;
    assign fill_s     = (state_r == ST_MISS) && !mem_ack_;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: a miss parks the cache until the refill is acknowledged
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (!fetch_e_ && !hit_s) begin
                    state_nxt_s = ST_MISS;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_MISS: begin
                if (!mem_ack_) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_MISS;
                end
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // Output logic: next values of the registered response and refill request
    always_comb begin
        ic_e_nxt_s     = 1'b1;
        ic_pc_nxt_s    = ic_pc;
        ic_inst_nxt_s  = ic_inst;
        mem_req_nxt_s  = 1'b1;
        mem_addr_nxt_s = mem_addr;
        case (state_r)
            ST_RUN: begin
                if (!fetch_e_) begin
                    if (hit_s) begin
                        ic_e_nxt_s    = 1'b0;
                        ic_pc_nxt_s   = fetch_pc;
                        ic_inst_nxt_s = data_r[req_idx_s];
                    end else begin
                        mem_req_nxt_s  = 1'b0;
                        mem_addr_nxt_s = {fetch_pc[ADDR-1:2], 2'b00};
                    end
                end else begin
                    mem_req_nxt_s = 1'b1;
                end
            end
            ST_MISS: begin
                if (!mem_ack_) begin
                    ic_e_nxt_s    = 1'b0;
                    ic_pc_nxt_s   = pc_r;
                    ic_inst_nxt_s = mem_inst;
                    mem_req_nxt_s = 1'b1;
                end else begin
                    mem_req_nxt_s = 1'b0;
                end
            end
            default: begin
                mem_req_nxt_s = 1'b1;
            end
        endcase
    end

    // Registered outputs and the PC of the outstanding request
    always_ff @(posedge clk) begin
        if (reset) begin
            ic_e_    <= 1'b1;
            ic_pc    <= {ADDR{1'b0}};
            ic_inst  <= {INST{1'b0}};
            mem_req_ <= 1'b1;
            mem_addr <= {ADDR{1'b0}};
            pc_r     <= {ADDR{1'b0}};
        end else begin
            ic_e_    <= ic_e_nxt_s;
            ic_pc    <= ic_pc_nxt_s;
            ic_inst  <= ic_inst_nxt_s;
            mem_req_ <= mem_req_nxt_s;
            mem_addr <= mem_addr_nxt_s;
            if (accept_s) begin
                pc_r <= fetch_pc;
            end
        end
    end

    // Valid bits: a refill landing in the same cycle as an invalidate survives it
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= {LINES{1'b0}};
        end else begin
            if (!inv_) begin
                valid_r <= {LINES{1'b0}};
            end
            if (fill_s) begin
                valid_r[fill_idx_s] <= 1'b1;
            end
        end
    end

    // Tag and data storage, written only by a refill
    always_ff @(posedge clk) begin
        if (fill_s) begin
            tag_r[fill_idx_s]  <= pc_r[ADDR-1:IDX+2];
            data_r[fill_idx_s] <= mem_inst;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    // Free-running wrapping hit/miss event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_hit  <= 32'd0;
            perf_miss <= 32'd0;
        end else begin
            if (accept_s && hit_s) begin
                perf_hit <= perf_hit + 32'd1;
            end
            if (accept_s && !hit_s) begin
                perf_miss <= perf_miss + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: directed scenarios then random traffic, all checked against
// a transaction-level cache model kept in the bench.
module tb_icache_dm;

    localparam int ADDR  = 32;
    localparam int INST  = 32;
    localparam int LINES = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            fetch_e_;
    logic [ADDR-1:0] fetch_pc;
    logic            ic_e_;
    logic [ADDR-1:0] ic_pc;
    logic [INST-1:0] ic_inst;
    logic            mem_req_;
    logic [ADDR-1:0] mem_addr;
    logic            mem_ack_;
    logic [INST-1:0] mem_inst;
    logic            inv_;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]     perf_hit;
    logic [31:0]     perf_miss;
`endif

    icache_dm #(.ADDR(ADDR), .INST(INST), .LINES(LINES)) dut (
        .clk      (clk),
        .reset    (reset),
        .fetch_e_ (fetch_e_),
        .fetch_pc (fetch_pc),
        .ic_e_    (ic_e_),
        .ic_pc    (ic_pc),
        .ic_inst  (ic_inst),
        .mem_req_ (mem_req_),
        .mem_addr (mem_addr),
        .mem_ack_ (mem_ack_),
        .mem_inst (mem_inst),
        .inv_     (inv_)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .perf_hit (perf_hit),
        .perf_miss(perf_miss)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: cache contents, one outstanding miss, expected outputs
    bit              m_valid [LINES];
    logic [31:0]     m_tag   [LINES];
    logic [31:0]     m_data  [LINES];
    bit              m_pend;
    logic [31:0]     m_pend_pc;
    logic            e_ic_e;
    logic [31:0]     e_ic_pc;
    logic [31:0]     e_ic_inst;
    logic            e_req;
    logic [31:0]     e_addr;
    logic [31:0]     e_hit;
    logic [31:0]     e_miss;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model_valid();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
    endtask

    // One cycle of the reference behaviour using the inputs currently driven
    task automatic model_step();
        int unsigned line;
        logic [31:0] tag;
        e_ic_e = 1'b1;
        if (reset) begin
            clear_model_valid();
            m_pend    = 1'b0;
            e_ic_pc   = 32'h0;
            e_ic_inst = 32'h0;
            e_req     = 1'b1;
            e_addr    = 32'h0;
            e_hit     = 32'h0;
            e_miss    = 32'h0;
        end else if (m_pend) begin
            if (!inv_) clear_model_valid();
            if (!mem_ack_) begin
                line          = (m_pend_pc / 4) % LINES;
                m_valid[line] = 1'b1;
                m_tag[line]   = m_pend_pc / (4 * LINES);
                m_data[line]  = mem_inst;
                e_ic_e        = 1'b0;
                e_ic_pc       = m_pend_pc;
                e_ic_inst     = mem_inst;
                e_req         = 1'b1;
                m_pend        = 1'b0;
            end
        end else begin
            if (!fetch_e_) begin
                line = (fetch_pc / 4) % LINES;
                tag  = fetch_pc / (4 * LINES);
                if (m_valid[line] && m_tag[line] == tag) begin
                    e_ic_e    = 1'b0;
                    e_ic_pc   = fetch_pc;
                    e_ic_inst = m_data[line];
                    e_hit     = e_hit + 32'd1;
                end else begin
                    m_pend    = 1'b1;
                    m_pend_pc = fetch_pc;
                    e_req     = 1'b0;
                    e_addr    = fetch_pc - (fetch_pc % 4);
                    e_miss    = e_miss + 32'd1;
                end
            end
            if (!inv_) clear_model_valid();
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_eq("ic_e_", ic_e_, e_ic_e);
        if (e_ic_e == 1'b0) begin
            check_eq("ic_pc", ic_pc, e_ic_pc);
            check_eq("ic_inst", ic_inst, e_ic_inst);
        end
        check_eq("mem_req_", mem_req_, e_req);
        if (e_req == 1'b0) begin
            check_eq("mem_addr", mem_addr, e_addr);
        end
`ifdef ICACHE_PERF_CNT_EN
        check_eq("perf_hit", perf_hit, e_hit);
        check_eq("perf_miss", perf_miss, e_miss);
`endif
    endtask

    task automatic drive(input logic f, input logic [31:0] pc, input logic ack,
                         input logic [31:0] mi, input logic inv, input logic rst);
        fetch_e_ = f;
        fetch_pc = pc;
        mem_ack_ = ack;
        mem_inst = mi;
        inv_     = inv;
        reset    = rst;
        cycle();
    endtask

    initial begin
        logic [31:0] rpc;
        clear_model_valid();
        m_pend = 1'b0;
        e_hit  = 32'h0;
        e_miss = 32'h0;

        // Reset state
        drive(1'b1, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1);
        drive(1'b1, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1);
        check_eq("rst_ic_e_", ic_e_, 1'b1);
        check_eq("rst_mem_req_", mem_req_, 1'b1);
        check_eq("rst_mem_addr", mem_addr, 32'h0);

        // First miss on 0x100, refilled with 0xDEADBEEF
        drive(1'b0, 32'h100, 1'b1, 32'h0, 1'b1, 1'b0);
        check_eq("tp_miss_addr", mem_addr, 32'h100);
        drive(1'b1, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0);
        check_eq("tp_fill_pc", ic_pc, 32'h100);
        check_eq("tp_fill_inst", ic_inst, 32'hDEADBEEF);

        // Hit on 0x100
        drive(1'b0, 32'h100, 1'b1, 32'h0, 1'b1, 1'b0);
        check_eq("tp_hit_e_", ic_e_, 1'b0);
        check_eq("tp_hit_inst", ic_inst, 32'hDEADBEEF);
        check_eq("tp_hit_req_", mem_req_, 1'b1);
`ifdef ICACHE_PERF_CNT_EN
        check_eq("tp_perf_hit", perf_hit, 32'd1);
        check_eq("tp_perf_miss", perf_miss, 32'd1);
`endif

        // Fill 0x104, then back-to-back hits on 0x100 and 0x104
        drive(1'b0, 32'h104, 1'b1, 32'h0, 1'b1, 1'b0);
        drive(1'b1, 32'h0, 1'b0, 32'h11111111, 1'b1, 1'b0);
        drive(1'b0, 32'h100, 1'b1, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h104, 1'b1, 32'h0, 1'b1, 1'b0);
        check_eq("tp_b2b_inst", ic_inst, 32'h11111111);

        // Conflict on index 0: 0x200 evicts 0x100
        drive(1'b0, 32'h200, 1'b1, 32'h0, 1'b1, 1'b0);
        check_eq("tp_conflict_addr", mem_addr, 32'h200);
        drive(1'b1, 32'h0, 1'b0, 32'h22222222, 1'b1, 1'b0);
        drive(1'b0, 32'h100, 1'b1, 32'h0, 1'b1, 1'b0);
        check_eq("tp_evicted_req_", mem_req_, 1'b0);
        drive(1'b1, 32'h0, 1'b0, 32'h33333333, 1'b1, 1'b0);

        // Invalidate then refetch 0x100
        drive(1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 32'h100, 1'b1, 32'h0, 1'b1, 1'b0);
        check_eq("tp_inv_req_", mem_req_, 1'b0);
        drive(1'b1, 32'h0, 1'b0, 32'h44444444, 1'b1, 1'b0);

        // Stalled refill on 0x300 with fetch_pc wandering
        drive(1'b0, 32'h300, 1'b1, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, $urandom, 1'b1, 32'h0, 1'b1, 1'b0);
            check_eq("tp_stall_addr", mem_addr, 32'h300);
            check_eq("tp_stall_e_", ic_e_, 1'b1);
        end
        drive(1'b1, 32'h0, 1'b0, 32'h55555555, 1'b1, 1'b0);
        check_eq("tp_stall_pc", ic_pc, 32'h300);

        // Reset while a miss is outstanding; the later ack must be ignored
        drive(1'b0, 32'h400, 1'b1, 32'h0, 1'b1, 1'b0);
        drive(1'b1, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1);
        check_eq("tp_rstmiss_req_", mem_req_, 1'b1);
        drive(1'b1, 32'h0, 1'b0, 32'h66666666, 1'b1, 1'b0);
        check_eq("tp_rstmiss_e_", ic_e_, 1'b1);

        // Random traffic over a small address pool to exercise hits, conflicts and invalidates
        for (int n = 0; n < 3000; n++) begin
            rpc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
                  | 32'($urandom_range(0, 3));
            drive(($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0, rpc,
                  ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, $urandom,
                  ($urandom_range(0, 99) < 4) ? 1'b0 : 1'b1,
                  ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
